// File: rtl/kernel_scatter.sv
// kernel_scatter
//   Turns a byte stream into packed channel words. Every four accepted bytes
//   form one word: byte n goes to lane n, and lane k is kernel 4g+k. A job is
//   G = NO_OF_KERNEL/4 groups of C words each. Completed words pass through a
//   one-entry staging register and then into a small FIFO that feeds the
//   output handshake.
//
// Ports
//   i_clk, i_rst_n           clock (rising edge), async active-low reset
//   i_start                  job start pulse, honoured only when idle
//   i_channel_per_kernel     channels per kernel C, sampled at start
//   i_s_data/i_s_valid       input byte stream
//   o_s_ready                byte can be accepted this cycle
//   o_m_data/o_m_valid       packed word at the FIFO head
//   i_m_ready                downstream takes the word
//   o_m_last                 word is the last channel of its group
//   o_group_idx              group of the word on o_m_data
//   o_busy                   job in progress (PACK or DRAIN)
//   o_done                   one-cycle pulse when the job is complete
module kernel_scatter #(
  parameter int DATA_WIDTH            = 32,
  parameter int NO_OF_KERNEL          = 16,
  parameter int N_CHANNEL_EACH_KERNEL = 32,
  parameter int FIFO_DEPTH            = 4,
  localparam int L  = DATA_WIDTH / 4,
  localparam int G  = NO_OF_KERNEL / 4,
  localparam int GW = (G > 1) ? $clog2(G) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [6:0]            i_channel_per_kernel,
  input  logic [L-1:0]          i_s_data,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic                  o_m_last,
  output logic [GW-1:0]         o_group_idx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, PACK, DRAIN, DONE} state_t;

  state_t state, state_next;

  // Job bookkeeping
  logic [6:0]    c_reg;
  logic [6:0]    word_cnt;
  logic [GW-1:0] grp;
  logic [1:0]    byte_cnt;
  logic [3*L-1:0] pack_reg;
  logic          feed_done;   // final word of the job has been assembled

  // Staging register between packer and FIFO
  logic                  pend_valid;
  logic [DATA_WIDTH-1:0] pend_data;
  logic                  pend_last;
  logic [GW-1:0]         pend_grp;

  // Output FIFO
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];
  logic [GW-1:0]         mem_grp  [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;

  logic fifo_full, fifo_empty, push, pop, byte_acc, start_ok, word_is_last;
  logic [6:0] c_in;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign pop        = !fifo_empty && i_m_ready;
  assign push       = pend_valid;
  assign byte_acc   = i_s_valid && o_s_ready;
  assign start_ok   = (state == IDLE) && i_start;
  assign word_is_last = (word_cnt == c_reg - 7'd1);
  assign c_in = (i_channel_per_kernel == 7'd0 ||
                 i_channel_per_kernel > 7'(N_CHANNEL_EACH_KERNEL))
                ? 7'(N_CHANNEL_EACH_KERNEL) : i_channel_per_kernel;

  // NOTE: state and all other registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_s_ready  = 1'b0;
    case (state)
      IDLE: if (i_start) state_next = PACK;
      PACK: begin
        o_busy    = 1'b1;
        // A pop in the same cycle frees the slot the next word would need.
        o_s_ready = !feed_done && (!fifo_full || pop);
        if (pend_valid && pend_last && pend_grp == GW'(G - 1))
          state_next = DRAIN;
      end
      DRAIN: begin
        o_busy = 1'b1;
        if (fifo_empty) state_next = DONE;
      end
      DONE: begin
        o_done     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Packer: bytes shift in from the top so byte n ends up in lane n.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      c_reg      <= '0;
      word_cnt   <= '0;
      grp        <= '0;
      byte_cnt   <= '0;
      pack_reg   <= '0;
      feed_done  <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_last  <= 1'b0;
      pend_grp   <= '0;
    end else begin
      pend_valid <= 1'b0;
      if (start_ok) begin
        c_reg     <= c_in;
        word_cnt  <= '0;
        grp       <= '0;
        byte_cnt  <= '0;
        feed_done <= 1'b0;
      end else if (byte_acc) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          pend_valid <= 1'b1;
          pend_data  <= {i_s_data, pack_reg};
          pend_last  <= word_is_last;
          pend_grp   <= grp;
          if (word_is_last) begin
            word_cnt <= '0;
            if (grp == GW'(G - 1)) begin
              grp       <= '0;
              feed_done <= 1'b1;
            end else begin
              grp <= grp + 1'b1;
            end
          end else begin
            word_cnt <= word_cnt + 7'd1;
          end
        end else begin
          pack_reg <= {i_s_data, pack_reg[3*L-1:L]};
        end
      end
    end
  end

  // NOTE: FIFO storage has no reset; only pointers and count are reset, and
  // the outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_data[wr_ptr] <= pend_data;
      mem_last[wr_ptr] <= pend_last;
      mem_grp[wr_ptr]  <= pend_grp;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign o_m_valid   = !fifo_empty;
  assign o_m_data    = fifo_empty ? '0   : mem_data[rd_ptr];
  assign o_m_last    = fifo_empty ? 1'b0 : mem_last[rd_ptr];
  assign o_group_idx = fifo_empty ? '0   : mem_grp[rd_ptr];

endmodule

// File: tb/tb_kernel_scatter.sv
// Testbench for kernel_scatter with default parameters (32-bit words,
// 4 groups per job, up to 32 channels, 4-deep output FIFO).
// Expected words come from a job-level model: word w is bytes 4w..4w+3,
// its group is w/C and it is last when w%C == C-1.
module tb_kernel_scatter;

  localparam int DEPTH = 4;
  localparam int NCH   = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  channel = '0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic [1:0]  group_idx;
  logic        busy;
  logic        done;

  kernel_scatter dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_start             (start),
    .i_channel_per_kernel(channel),
    .i_s_data            (s_data),
    .i_s_valid           (s_valid),
    .o_s_ready           (s_ready),
    .o_m_data            (m_data),
    .o_m_valid           (m_valid),
    .i_m_ready           (m_ready),
    .o_m_last            (m_last),
    .o_group_idx         (group_idx),
    .o_busy              (busy),
    .o_done              (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  job_bytes [512];
  int          nbytes;
  int          idx;
  int          cyc;
  int          done_cnt;
  int          total_done = 0;
  int          acc4_cyc;
  int          first_valid_cyc;
  logic [63:0] exp_q [$];
  logic [63:0] got   [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_tag(input int g, input bit lst, input logic [31:0] w);
    return (64'(g) << 33) | (64'(lst) << 32) | 64'(w);
  endfunction

  function automatic logic [63:0] out_tag();
    return pack_tag(int'(group_idx), m_last, m_data);
  endfunction

  // Fill the byte stream and build the expected word list for a job.
  task automatic prepare_job(input int c_in, input bit seq);
    int ce;
    ce = (c_in == 0 || c_in > NCH) ? NCH : c_in;
    nbytes = 16 * ce;
    for (int i = 0; i < nbytes; i++)
      job_bytes[i] = seq ? 8'(i) : 8'($urandom);
    exp_q.delete();
    got.delete();
    for (int w = 0; w < 4 * ce; w++)
      exp_q.push_back(pack_tag(w / ce, (w % ce) == ce - 1,
        {job_bytes[4*w+3], job_bytes[4*w+2], job_bytes[4*w+1], job_bytes[4*w]}));
    idx = 0; cyc = 0; done_cnt = 0; acc4_cyc = -1; first_valid_cyc = -1;
  endtask

  // One clock: drive at the falling edge, observe 1 time unit later.
  task automatic step(input bit sv, input bit mr, input bit st, input logic [6:0] ch);
    @(negedge clk);
    start   = st;
    channel = ch;
    s_valid = sv;
    m_ready = mr;
    s_data  = (idx < nbytes) ? job_bytes[idx] : 8'($urandom);
    #1;
    cyc++;
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (s_valid && s_ready) begin
      idx++;
      if (idx == 4) acc4_cyc = cyc;
    end
    if (m_valid && m_ready) begin
      got.push_back(out_tag());
      if (exp_q.size() == 0) check("extra_word", 64'(1), 64'(0));
      else                   check("word", out_tag(), exp_q.pop_front());
    end
    if (done) done_cnt++;
  endtask

  // Run a whole job. vprob/rprob: percent chance of s_valid / m_ready.
  // hold: leading cycles with m_ready=0 and s_valid=1. restart_at: cycle at
  // which a second start (with a different C) is pulsed mid-job.
  task automatic run_job(input int c_in, input int vprob, input int rprob,
                         input int hold, input int restart_at, input bit seq);
    bit sv, mr;
    int nwords;
    prepare_job(c_in, seq);
    nwords = exp_q.size();
    step(1'b0, 1'b1, 1'b1, 7'(c_in));
    for (int k = 0; k < 20000 && done_cnt == 0; k++) begin
      sv = ($urandom_range(99) < vprob);
      mr = ($urandom_range(99) < rprob);
      if (k < hold) begin sv = 1'b1; mr = 1'b0; end
      step(sv, mr, k == restart_at, 7'd5);
      if (k == restart_at) check("busy_at_restart", 64'(busy), 64'(1));
      if (hold > 0 && k == hold / 2)
        check("hold_data_mid", 64'(m_data), 64'(exp_q[0][31:0]));
      if (hold > 0 && k == hold - 1) begin
        check("hold_s_ready", 64'(s_ready), 64'(0));
        check("hold_m_valid", 64'(m_valid), 64'(1));
        check("hold_bytes", 64'(idx), 64'(4 * DEPTH + 1));
        check("hold_data_end", 64'(m_data), 64'(exp_q[0][31:0]));
      end
    end
    if (done_cnt == 0) check("done_timeout", 64'(0), 64'(1));
    step(1'b0, 1'b1, 1'b0, 7'd5);
    step(1'b1, 1'b1, 1'b0, 7'd5);
    total_done += done_cnt;
    check("done_pulses", 64'(done_cnt), 64'(1));
    check("busy_after", 64'(busy), 64'(0));
    check("bytes_taken", 64'(idx), 64'(nbytes));
    check("word_count", 64'(got.size()), 64'(nwords));
    check("latency", 64'(first_valid_cyc - acc4_cyc), 64'(2));
  endtask

  initial begin
    int lasts;
    bit ok_pos;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs",
          {27'b0, s_ready, m_valid, m_last, busy, done, group_idx, m_data},
          64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // C=2, sequential bytes, free-flowing handshake
    run_job(2, 100, 100, 0, -1, 1'b1);
    check("c2_word0", got[0], pack_tag(0, 1'b0, 32'h03020100));
    check("c2_word1_last", 64'(got[1][32]), 64'(1));
    check("c2_word7", got[7], pack_tag(3, 1'b1, 32'h1F1E1D1C));

    // C=0 and C=100 both fall back to 32 channels
    for (int t = 0; t < 2; t++) begin
      run_job((t == 0) ? 0 : 100, 90, 90, 0, -1, 1'b0);
      lasts = 0;
      ok_pos = 1'b1;
      for (int i = 0; i < got.size(); i++)
        if (got[i][32]) begin
          lasts++;
          if ((i % 32) != 31) ok_pos = 1'b0;
        end
      check("cmax_words", 64'(got.size()), 64'(128));
      check("cmax_lasts", 64'(lasts), 64'(4));
      check("cmax_last_pos", 64'(ok_pos), 64'(1));
    end

    // Downstream stalled through PACK, then released
    run_job(2, 100, 100, 40, -1, 1'b0);

    // Random handshakes over 4 jobs, one with a start pulse while busy
    total_done = 0;
    for (int j = 0; j < 4; j++)
      run_job($urandom_range(1, 33), $urandom_range(30, 95), $urandom_range(30, 95),
              0, (j == 1) ? 10 : -1, 1'b0);
    check("random_done_total", 64'(total_done), 64'(4));

    // Reset after two bytes of group 1
    prepare_job(2, 1'b0);
    step(1'b0, 1'b0, 1'b1, 7'd2);
    for (int k = 0; k < 200 && idx < 10; k++) step(1'b1, 1'b0, 1'b0, 7'd2);
    check("pre_reset_bytes", 64'(idx), 64'(10));
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midjob_reset_outputs",
          {27'b0, s_ready, m_valid, m_last, busy, done, group_idx, m_data},
          64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 7'd2);
    step(1'b1, 1'b1, 1'b0, 7'd2);
    check("idle_after_reset", {62'b0, busy, m_valid}, 64'(0));
    run_job(3, 80, 80, 0, -1, 1'b0);
    check("post_reset_word0", 64'(got[0][31:0]),
          64'({job_bytes[3], job_bytes[2], job_bytes[1], job_bytes[0]}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
